// File: rtl/uart_mem_loader.sv
// UART 8N1 receiver that packs big-endian byte pairs into 16-bit words and
// writes them to sequential RAM addresses while a load session is enabled.
module uart_mem_loader #(
  parameter int         CLKS_PER_BIT = 434,
  parameter logic [7:0] LAST_ADDR    = 8'hFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  input  logic        load_en,
  output logic        mem_we,
  output logic [7:0]  mem_addr,
  output logic [15:0] mem_din,
  output logic        busy,
  output logic        done,
  output logic        frame_err,
  output logic [8:0]  word_count
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {P_HI, P_LO, P_WRITE} p_state_t;

  // Receiver state
  logic             rx_meta_reg, rx_sync_reg;
  rx_state_t        rx_state_reg, rx_state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       bit_reg, bit_next;
  logic [7:0]       shift_reg, shift_next;
  logic             byte_valid_reg, byte_valid_next;
  logic             stop_err_reg, stop_err_next;

  // Packer state
  p_state_t   p_state_reg, p_state_next;
  logic       load_en_reg;
  logic [7:0] hi_reg, hi_next, lo_reg, lo_next;
  logic [7:0] addr_reg, addr_next;
  logic [8:0] count_reg, count_next;
  logic       done_reg, done_next;
  logic       ferr_reg, ferr_next;
  logic       load_rise;

  assign load_rise = load_en & ~load_en_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_reg    <= 1'b1;
      rx_sync_reg    <= 1'b1;
      rx_state_reg   <= RX_IDLE;
      cnt_reg        <= '0;
      bit_reg        <= '0;
      shift_reg      <= '0;
      byte_valid_reg <= 1'b0;
      stop_err_reg   <= 1'b0;
    end else begin
      rx_meta_reg    <= rx;
      rx_sync_reg    <= rx_meta_reg;
      rx_state_reg   <= rx_state_next;
      cnt_reg        <= cnt_next;
      bit_reg        <= bit_next;
      shift_reg      <= shift_next;
      byte_valid_reg <= byte_valid_next;
      stop_err_reg   <= stop_err_next;
    end
  end

  always_comb begin
    rx_state_next   = rx_state_reg;
    cnt_next        = cnt_reg + CNT_W'(1);
    bit_next        = bit_reg;
    shift_next      = shift_reg;
    byte_valid_next = 1'b0;
    stop_err_next   = 1'b0;
    case (rx_state_reg)
      RX_IDLE: begin
        cnt_next = '0;
        if (!rx_sync_reg) rx_state_next = RX_START;
      end
      RX_START: begin
        // Mid-start-bit recheck rejects short glitches on the line
        if (cnt_reg == HALF_END) begin
          cnt_next      = '0;
          bit_next      = '0;
          rx_state_next = rx_sync_reg ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_reg == BIT_END) begin
          cnt_next   = '0;
          shift_next = {rx_sync_reg, shift_reg[7:1]};
          bit_next   = bit_reg + 3'd1;
          if (bit_reg == 3'd7) rx_state_next = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_reg == BIT_END) begin
          cnt_next        = '0;
          byte_valid_next = rx_sync_reg;
          stop_err_next   = ~rx_sync_reg;
          rx_state_next   = RX_IDLE;
        end
      end
      default: rx_state_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_state_reg <= P_HI;
      load_en_reg <= 1'b0;
      hi_reg      <= '0;
      lo_reg      <= '0;
      addr_reg    <= '0;
      count_reg   <= '0;
      done_reg    <= 1'b0;
      ferr_reg    <= 1'b0;
    end else begin
      p_state_reg <= p_state_next;
      load_en_reg <= load_en;
      hi_reg      <= hi_next;
      lo_reg      <= lo_next;
      addr_reg    <= addr_next;
      count_reg   <= count_next;
      done_reg    <= done_next;
      ferr_reg    <= ferr_next;
    end
  end

  always_comb begin
    p_state_next = p_state_reg;
    hi_next      = hi_reg;
    lo_next      = lo_reg;
    addr_next    = addr_reg;
    count_next   = count_reg;
    done_next    = done_reg;
    ferr_next    = ferr_reg;
    if (load_rise) begin
      // Restart wins over any byte arriving in the same cycle
      p_state_next = P_HI;
      addr_next    = '0;
      count_next   = '0;
      done_next    = 1'b0;
      ferr_next    = 1'b0;
    end else begin
      case (p_state_reg)
        P_HI: begin
          if (byte_valid_reg && load_en_reg && !done_reg) begin
            hi_next      = shift_reg;
            p_state_next = P_LO;
          end
        end
        P_LO: begin
          if (!load_en_reg) begin
            p_state_next = P_HI;
          end else if (byte_valid_reg) begin
            lo_next      = shift_reg;
            p_state_next = P_WRITE;
          end
        end
        P_WRITE: begin
          // The strobe completes even if load_en dropped; address holds at the end
          p_state_next = P_HI;
          if (count_reg != 9'd256) count_next = count_reg + 9'd1;
          if (addr_reg == LAST_ADDR) done_next = 1'b1;
          else                       addr_next = addr_reg + 8'd1;
        end
        default: p_state_next = P_HI;
      endcase
      if (stop_err_reg) begin
        ferr_next = 1'b1;
        if (p_state_reg != P_WRITE) p_state_next = P_HI;
      end
    end
  end

  assign mem_we     = (p_state_reg == P_WRITE);
  assign mem_addr   = addr_reg;
  assign mem_din    = {hi_reg, lo_reg};
  assign busy       = load_en_reg & ~done_reg;
  assign done       = done_reg;
  assign frame_err  = ferr_reg;
  assign word_count = count_reg;

endmodule

// File: tb/tb_uart_mem_loader.sv
// Scoreboard bench for uart_mem_loader: stimulus queues expected RAM writes,
// a negedge monitor pops and compares each mem_we strobe.
module tb_uart_mem_loader;

  localparam int CPB = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx;
  logic        load_en;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_din;
  logic        busy;
  logic        done;
  logic        frame_err;
  logic [8:0]  word_count;

  uart_mem_loader #(.CLKS_PER_BIT(CPB), .LAST_ADDR(8'h03)) dut (
    .clk(clk), .reset(reset), .rx(rx), .load_en(load_en),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .busy(busy), .done(done), .frame_err(frame_err), .word_count(word_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  total = 0;
  int  bad   = 0;
  int  cyc   = 0;
  int  prev_we_cyc = 0;
  bit  have_prev = 1'b0;

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: every strobe must match the head of the expected queue
  always @(negedge clk) begin
    if (mem_we) begin
      wr_t e;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_we: addr=0x%0h data=0x%0h with no write expected", mem_addr, mem_din);
      end else begin
        e = exp_q.pop_front();
        chk("we_addr", 40'(mem_addr), 40'(e.addr));
        chk("we_data", 40'(mem_din), 40'(e.data));
      end
      if (have_prev) chk("we_spacing_ok", 40'((cyc - prev_we_cyc) >= 20 * CPB), 40'd1);
      prev_we_cyc = cyc;
      have_prev   = 1'b1;
    end
  end

  function automatic logic [39:0] all_outs();
    return 40'({mem_we, mem_addr, mem_din, busy, done, frame_err, word_count});
  endfunction

  task automatic push(input logic [7:0] a, input logic [15:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  // Called and returns on a negedge; a full byte takes exactly 10*CPB cycles
  task automatic send_byte(input logic [7:0] b, input logic stop, input int nbits);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    if (nbits == 8) begin
      rx = stop;
      repeat (CPB) @(negedge clk);
      rx = 1'b1;
    end
  endtask

  task automatic send_word(input logic [15:0] w);
    send_byte(w[15:8], 1'b1, 8);
    send_byte(w[7:0], 1'b1, 8);
  endtask

  task automatic new_session(input string tag);
    load_en = 1'b0;
    repeat (4) @(negedge clk);
    load_en = 1'b1;
    repeat (3) @(negedge clk);
    chk({tag, "_clear"}, 40'({mem_addr, word_count, done, frame_err}), 40'd0);
    chk({tag, "_busy"}, 40'(busy), 40'd1);
  endtask

  task automatic settle(input string tag);
    repeat (6) @(negedge clk);
    chk({tag, "_pending"}, 40'(exp_q.size()), 40'd0);
  endtask

  initial begin
    reset   = 1'b1;
    rx      = 1'b1;
    load_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs", all_outs(), 40'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Single word
    new_session("t1");
    push(8'h00, 16'h1234);
    send_word(16'h1234);
    settle("t1");
    chk("t1_addr", 40'(mem_addr), 40'h01);
    chk("t1_count", 40'(word_count), 40'd1);

    // Three words, spacing checked by the monitor
    new_session("t2");
    push(8'h00, 16'hA5A5);
    push(8'h01, 16'h0F0F);
    push(8'h02, 16'hFFFF);
    send_word(16'hA5A5);
    send_word(16'h0F0F);
    send_word(16'hFFFF);
    settle("t2");
    chk("t2_addr", 40'(mem_addr), 40'h03);
    chk("t2_count", 40'(word_count), 40'd3);
    chk("t2_done", 40'(done), 40'd0);

    // LAST_ADDR=3: fifth word must not write
    new_session("t3");
    for (int i = 0; i < 4; i++) push(8'(i), 16'h1100 + 16'(i));
    for (int i = 0; i < 4; i++) send_word(16'h1100 + 16'(i));
    settle("t3a");
    chk("t3_done", 40'(done), 40'd1);
    chk("t3_busy", 40'(busy), 40'd0);
    send_word(16'hDEAD);
    settle("t3b");
    chk("t3_addr_hold", 40'(mem_addr), 40'h03);
    chk("t3_count", 40'(word_count), 40'd4);

    // Frame error on the first byte, then a good word
    new_session("t4");
    send_byte(8'h55, 1'b0, 8);
    repeat (2 * CPB) @(negedge clk);
    chk("t4_ferr_set", 40'(frame_err), 40'd1);
    push(8'h00, 16'hABCD);
    send_word(16'hABCD);
    settle("t4");
    chk("t4_ferr_sticky", 40'(frame_err), 40'd1);
    chk("t4_addr", 40'(mem_addr), 40'h01);

    // Short glitch is ignored
    new_session("t5");
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    chk("t5_no_err", 40'(frame_err), 40'd0);
    push(8'h00, 16'h0102);
    send_word(16'h0102);
    settle("t5");
    chk("t5_count", 40'(word_count), 40'd1);

    // Reset in the middle of the low byte
    new_session("t6");
    send_byte(8'h77, 1'b1, 8);
    send_byte(8'h88, 1'b1, 3);
    reset   = 1'b1;
    load_en = 1'b0;
    rx      = 1'b1;
    @(negedge clk);
    chk("t6_reset_outs", all_outs(), 40'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    chk("t6_quiet_after_reset", 40'({mem_we, mem_addr, word_count}), 40'd0);
    new_session("t6b");
    push(8'h00, 16'h9ABC);
    send_word(16'h9ABC);
    settle("t6");
    chk("t6_addr", 40'(mem_addr), 40'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
